// File: rtl/case_5_mul_pipe_acc.sv
// ---------------------------------------------------------------------------
// case_5_mul_pipe_acc
//   Pipelined signed/unsigned multiplier with optional multiply-accumulate and
//   a sticky overflow flag.
//
//   Every result emerges NUM_STAGE ce-enabled edges after it is accepted,
//   counting the acceptance edge itself as the first. Results come out in order,
//   at one per ce cycle, and there is no backpressure. The accumulator lives in
//   the final stage, so back-to-back accumulate transactions chain without any
//   hazard logic.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset, overrides ce_i
//   ce_i         clock enable; 0 freezes every register
//   in_valid_i   din0_i/din1_i/acc_mode_i/acc_clr_i are sampled when ce_i=1
//   din0_i       operand 0 (din0_WIDTH)
//   din1_i       operand 1 (din1_WIDTH)
//   acc_mode_i   0 = plain multiply, 1 = accumulate the product
//   acc_clr_i    with acc_mode_i=1, the accumulator is taken as 0
//   out_valid_o  dout_o holds a new result
//   dout_o       result (dout_WIDTH)
//   ovf_o        sticky overflow (truncation or accumulate overflow)
// ---------------------------------------------------------------------------
module case_5_mul_pipe_acc #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 26,
    parameter int SIGNED     = 1,
    parameter int ACC_EN     = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ce_i,
    input  logic                  in_valid_i,
    input  logic [din0_WIDTH-1:0] din0_i,
    input  logic [din1_WIDTH-1:0] din1_i,
    input  logic                  acc_mode_i,
    input  logic                  acc_clr_i,
    output logic                  out_valid_o,
    output logic [dout_WIDTH-1:0] dout_o,
    output logic                  ovf_o
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int DW = dout_WIDTH;

    // ID is only an instance tag. An illegal stage count leaves this empty
    // block visible in the elaborated hierarchy.
    if (NUM_STAGE < 1 || ID < 0) begin : g_bad_params
    end

    // Extending both operands to the full product width makes a plain
    // PW-bit multiply produce the exact signed or unsigned product.
    function automatic logic [PW-1:0] mul_full(input logic [din0_WIDTH-1:0] a,
                                               input logic [din1_WIDTH-1:0] b);
        logic [PW-1:0] a_ext;
        logic [PW-1:0] b_ext;
        a_ext = {{din1_WIDTH{(SIGNED != 0) & a[din0_WIDTH-1]}}, a};
        b_ext = {{din0_WIDTH{(SIGNED != 0) & b[din1_WIDTH-1]}}, b};
        return a_ext * b_ext;
    endfunction

    logic mode_in;
    logic clr_in;
    assign mode_in = (ACC_EN != 0) && acc_mode_i;
    assign clr_in  = (ACC_EN != 0) && acc_clr_i;

    // Signals entering the final (output / accumulator) stage
    logic          fin_v;
    logic          fin_mode;
    logic          fin_clr;
    logic [PW-1:0] fin_p;

    if (NUM_STAGE == 1) begin : g_single
        assign fin_v    = in_valid_i;
        assign fin_mode = mode_in;
        assign fin_clr  = clr_in;
        assign fin_p    = mul_full(din0_i, din1_i);
    end else begin : g_multi
        logic                  s1_v_q;
        logic                  s1_mode_q;
        logic                  s1_clr_q;
        logic [din0_WIDTH-1:0] s1_a_q;
        logic [din1_WIDTH-1:0] s1_b_q;
        logic [PW-1:0]         p_c;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                s1_v_q    <= 1'b0;
                s1_mode_q <= 1'b0;
                s1_clr_q  <= 1'b0;
                s1_a_q    <= '0;
                s1_b_q    <= '0;
            end else if (ce_i) begin
                s1_v_q    <= in_valid_i;
                s1_mode_q <= mode_in;
                s1_clr_q  <= clr_in;
                s1_a_q    <= din0_i;
                s1_b_q    <= din1_i;
            end
        end

        assign p_c = mul_full(s1_a_q, s1_b_q);

        if (NUM_STAGE == 2) begin : g_direct
            assign fin_v    = s1_v_q;
            assign fin_mode = s1_mode_q;
            assign fin_clr  = s1_clr_q;
            assign fin_p    = p_c;
        end else begin : g_retime
            localparam int RS = NUM_STAGE - 2;

            logic [RS-1:0] rt_v_q;
            logic [RS-1:0] rt_mode_q;
            logic [RS-1:0] rt_clr_q;
            logic [PW-1:0] rt_p_q [RS];

            // Only the valids need clearing; payload behind a zero valid is
            // never consumed.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    rt_v_q <= '0;
                end else if (ce_i) begin
                    rt_v_q[0]    <= s1_v_q;
                    rt_mode_q[0] <= s1_mode_q;
                    rt_clr_q[0]  <= s1_clr_q;
                    rt_p_q[0]    <= p_c;
                    for (int i = 1; i < RS; i++) begin
                        rt_v_q[i]    <= rt_v_q[i-1];
                        rt_mode_q[i] <= rt_mode_q[i-1];
                        rt_clr_q[i]  <= rt_clr_q[i-1];
                        rt_p_q[i]    <= rt_p_q[i-1];
                    end
                end
            end

            assign fin_v    = rt_v_q[RS-1];
            assign fin_mode = rt_mode_q[RS-1];
            assign fin_clr  = rt_clr_q[RS-1];
            assign fin_p    = rt_p_q[RS-1];
        end
    end

    // Resize the full product to the result width and flag lost information
    logic [DW-1:0] r_c;
    logic          trunc_c;

    if (DW > PW) begin : g_ext
        assign r_c     = {{(DW-PW){(SIGNED != 0) & fin_p[PW-1]}}, fin_p};
        assign trunc_c = 1'b0;
    end else if (DW == PW) begin : g_same
        assign r_c     = fin_p;
        assign trunc_c = 1'b0;
    end else begin : g_trunc
        assign r_c = fin_p[DW-1:0];
        if (SIGNED != 0) begin : g_s
            // Representable only if every dropped bit equals the new sign bit
            assign trunc_c = (fin_p[PW-1:DW-1] != {(PW-DW+1){fin_p[DW-1]}});
        end else begin : g_u
            assign trunc_c = (fin_p[PW-1:DW] != '0);
        end
    end

    // Final stage: output register, accumulator and sticky overflow
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] acc_base;
    logic [DW-1:0] sum_c;
    logic          carry_c;
    logic          add_ovf_c;

    always_comb begin
        acc_base           = fin_clr ? '0 : acc_q;
        {carry_c, sum_c}   = {1'b0, acc_base} + {1'b0, r_c};
        if (SIGNED != 0) begin
            add_ovf_c = (acc_base[DW-1] == r_c[DW-1]) && (sum_c[DW-1] != acc_base[DW-1]);
        end else begin
            add_ovf_c = carry_c;
        end

        out_valid_d = fin_v;
        dout_d      = dout_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        if (fin_v) begin
            if (fin_mode) begin
                dout_d = sum_c;
                acc_d  = sum_c;
                // A fresh accumulation clears the flag before its own overflow
                ovf_d  = (ovf_q & ~fin_clr) | trunc_c | add_ovf_c;
            end else begin
                dout_d = r_c;
                ovf_d  = ovf_q | trunc_c;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (ce_i) begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign dout_o      = dout_q;
    assign ovf_o       = ovf_q;

endmodule
